// File: rtl/fwd_round_tf.sv
// One forward AES round: four S-box lookups per cycle over SUB (one column per cycle),
// then ShiftRows, optional MixColumns and AddRoundKey in a single MIX cycle.
module fwd_round_tf (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] b_i,
  input  logic [127:0] rk_i,
  input  logic         bypass_mc,
  output logic [127:0] b_sr_o,
  output logic [127:0] b_o,
  output logic         done_o,
  output logic         busy_o
);

  typedef enum logic [1:0] {IDLE, SUB, MIX} state_t;

  localparam logic [7:0] INV_EXP = 8'hFE;

  state_t        state;
  logic [1:0]    cnt;
  logic [127:0]  st_r;
  logic [127:0]  key_r;
  logic          byp_r;
  logic [31:0]   col_in;
  logic [31:0]   col_out;
  logic [0:15][7:0] sb;
  logic [0:15][7:0] srb;
  logic [0:15][7:0] mcb;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0), followed by the FIPS-197 affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] inv;
    inv = 8'h01;
    for (int i = 7; i >= 0; i--) begin
      inv = gf_mul(inv, inv);
      if (INV_EXP[i]) inv = gf_mul(inv, a);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  always_comb begin
    col_in = st_r[127:96];
    case (cnt)
      2'd0: col_in = st_r[127:96];
      2'd1: col_in = st_r[95:64];
      2'd2: col_in = st_r[63:32];
      2'd3: col_in = st_r[31:0];
      default: col_in = st_r[127:96];
    endcase
  end

  assign col_out = {sbox(col_in[31:24]), sbox(col_in[23:16]),
                    sbox(col_in[15:8]),  sbox(col_in[7:0])};

  assign sb = st_r;

  // Byte 4c+r sits at row r, column c; ShiftRows pulls row r from column (c+r) mod 4.
  always_comb begin
    srb = '0;
    mcb = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        srb[4*c+r] = sb[4*((c+r)%4)+r];
      end
    end
    for (int c = 0; c < 4; c++) begin
      logic [7:0] a0, a1, a2, a3;
      a0 = srb[4*c];
      a1 = srb[4*c+1];
      a2 = srb[4*c+2];
      a3 = srb[4*c+3];
      mcb[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      mcb[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      mcb[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      mcb[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= 2'd0;
      st_r   <= '0;
      key_r  <= '0;
      byp_r  <= 1'b0;
      b_sr_o <= '0;
      b_o    <= '0;
      done_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            st_r  <= b_i;
            key_r <= rk_i;
            byp_r <= bypass_mc;
            cnt   <= 2'd0;
            state <= SUB;
          end
        end
        SUB: begin
          case (cnt)
            2'd0: st_r[127:96] <= col_out;
            2'd1: st_r[95:64]  <= col_out;
            2'd2: st_r[63:32]  <= col_out;
            2'd3: st_r[31:0]   <= col_out;
            default: st_r[127:96] <= col_out;
          endcase
          cnt <= cnt + 2'd1;
          if (cnt == 2'd3) state <= MIX;
        end
        MIX: begin
          b_sr_o <= srb;
          b_o    <= (byp_r ? srb : mcb) ^ key_r;
          done_o <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy_o = (state != IDLE);

endmodule

// File: tb/tb_fwd_round_tf.sv
// Bench for fwd_round_tf: directed FIPS-197 vectors plus randomized traffic checked every
// cycle against a round-level reference model with its own S-box derivation.
module tb_fwd_round_tf;

  logic         clk;
  logic         rst;
  logic         start;
  logic [127:0] b_i;
  logic [127:0] rk_i;
  logic         bypass_mc;
  logic [127:0] b_sr_o;
  logic [127:0] b_o;
  logic         done_o;
  logic         busy_o;

  int n_checks;
  int n_fail;

  logic [7:0]   sbox_tab [256];
  logic [127:0] m_bo, m_bsr, p_o, p_sr;
  logic         m_done;
  int           m_rem;
  logic         model_ready;

  localparam logic [127:0] V_B   = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] V_K   = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] V_SR  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam logic [127:0] V_O   = 128'ha49c7ff2689f352b6b5bea43026a5049;
  localparam logic [127:0] ALL63 = {16{8'h63}};
  localparam logic [127:0] ALL9C = {16{8'h9c}};
  localparam logic [127:0] ALLFF = {16{8'hff}};

  fwd_round_tf dut (
    .clk(clk), .rst(rst), .start(start), .b_i(b_i), .rk_i(rk_i),
    .bypass_mc(bypass_mc), .b_sr_o(b_sr_o), .b_o(b_o),
    .done_o(done_o), .busy_o(busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] mul2(input logic [7:0] x);
    return (x << 1) ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] aa;
    logic [7:0] bb;
    acc = 0; aa = a; bb = b;
    while (bb != 0) begin
      if (bb[0]) acc ^= aa;
      aa = mul2(aa);
      bb = bb >> 1;
    end
    return acc;
  endfunction

  // S-box from a brute-force inverse search and the bitwise affine formula.
  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] s;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ ((8'h63 >> i) & 1);
      sbox_tab[a] = s;
    end
  endtask

  task automatic round_ref(input logic [127:0] b, input logic [127:0] k, input logic byp,
                           output logic [127:0] sr, output logic [127:0] o);
    logic [7:0] s [4][4];
    logic [7:0] t [4][4];
    logic [7:0] m [4][4];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        s[r][c] = sbox_tab[b[127-8*(4*c+r) -: 8]];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        t[r][c] = s[r][(c+r)%4];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        m[r][c] = mul2(t[r][c]) ^ mul2(t[(r+1)%4][c]) ^ t[(r+1)%4][c] ^ t[(r+2)%4][c] ^ t[(r+3)%4][c];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        sr[127-8*(4*c+r) -: 8] = t[r][c];
        o[127-8*(4*c+r) -: 8]  = (byp ? t[r][c] : m[r][c]) ^ k[127-8*(4*c+r) -: 8];
      end
  endtask

  task automatic checkOutput(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic st, input logic [127:0] b, input logic [127:0] k,
                               input logic byp);
    start     = st;
    b_i       = b;
    rk_i      = k;
    bypass_mc = byp;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Reference model: a round accepted while idle completes five edges later.
  always @(posedge clk) begin
    if (rst) begin
      m_bo = '0; m_bsr = '0; m_done = 1'b0; m_rem = 0;
    end else begin
      m_done = 1'b0;
      if (m_rem > 0) begin
        m_rem--;
        if (m_rem == 0) begin
          m_done = 1'b1;
          m_bo   = p_o;
          m_bsr  = p_sr;
        end
      end else if (start) begin
        round_ref(b_i, rk_i, bypass_mc, p_sr, p_o);
        m_rem = 5;
      end
    end
    model_ready = 1'b1;
  end

  always @(negedge clk) begin
    if (model_ready) begin
      checkOutput("cyc_b_o", b_o, m_bo);
      checkOutput("cyc_b_sr_o", b_sr_o, m_bsr);
      checkOutput("cyc_done_o", {127'b0, done_o}, {127'b0, m_done});
      checkOutput("cyc_busy_o", {127'b0, busy_o}, {127'b0, m_rem != 0});
    end
  end

  task automatic do_round(input string name, input logic [127:0] b, input logic [127:0] k,
                          input logic byp, input logic [127:0] exp_sr, input logic [127:0] exp_o,
                          input logic perturb);
    int  cyc;
    bit  seen;
    applyStimulus(1'b1, b, k, byp);
    @(negedge clk);
    cyc = 1;
    if (perturb) begin
      applyStimulus(1'b1, ~b, ~k, ~byp);
      @(negedge clk);
      cyc++;
    end
    applyStimulus(1'b0, rnd128(), rnd128(), 1'($urandom()));
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      cyc++;
      if (done_o) seen = 1;
    end
    checkOutput({name, "_done_seen"}, {127'b0, seen}, 128'd1);
    checkOutput({name, "_latency"}, 128'(cyc), 128'd6);
    checkOutput({name, "_b_sr_o"}, b_sr_o, exp_sr);
    checkOutput({name, "_b_o"}, b_o, exp_o);
  endtask

  initial begin
    int  dones;
    logic [127:0] tsr, to;
    n_checks = 0; n_fail = 0; model_ready = 1'b0;
    m_bo = '0; m_bsr = '0; m_done = 1'b0; m_rem = 0; p_o = '0; p_sr = '0;
    rst = 1'b1;
    applyStimulus(1'b0, '0, '0, 1'b0);
    build_sbox();

    checkOutput("model_sbox_00", {120'b0, sbox_tab[8'h00]}, 128'h63);
    checkOutput("model_sbox_01", {120'b0, sbox_tab[8'h01]}, 128'h7c);
    checkOutput("model_sbox_53", {120'b0, sbox_tab[8'h53]}, 128'hed);
    round_ref(V_B, V_K, 1'b0, tsr, to);
    checkOutput("model_fips_sr", tsr, V_SR);
    checkOutput("model_fips_o", to, V_O);

    repeat (2) @(negedge clk);
    checkOutput("reset_b_o", b_o, '0);
    checkOutput("reset_b_sr_o", b_sr_o, '0);
    checkOutput("reset_busy", {127'b0, busy_o}, '0);
    rst = 1'b0;
    @(negedge clk);

    do_round("fips", V_B, V_K, 1'b0, V_SR, V_O, 1'b0);
    do_round("final", '0, ALLFF, 1'b1, ALL63, ALL9C, 1'b0);
    do_round("uniform", '0, '0, 1'b0, ALL63, ALL63, 1'b0);
    do_round("ignore_busy_start", V_B, V_K, 1'b0, V_SR, V_O, 1'b1);

    // Abort in the third SUB cycle.
    applyStimulus(1'b1, '0, ALLFF, 1'b1);
    @(negedge clk);
    applyStimulus(1'b0, V_B, V_K, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort_b_o", b_o, '0);
    checkOutput("abort_b_sr_o", b_sr_o, '0);
    checkOutput("abort_busy", {127'b0, busy_o}, '0);
    checkOutput("abort_done", {127'b0, done_o}, '0);
    dones = 0;
    repeat (8) begin
      @(negedge clk);
      if (done_o) dones++;
    end
    checkOutput("abort_no_done", 128'(dones), 128'd0);
    do_round("after_abort", V_B, V_K, 1'b0, V_SR, V_O, 1'b0);

    // Start held high: one completion every six cycles, idle only while done.
    dones = 0;
    applyStimulus(1'b1, rnd128(), rnd128(), 1'($urandom()));
    for (int i = 0; i < 36; i++) begin
      @(negedge clk);
      if (done_o) dones++;
      checkOutput("held_busy_vs_done", {127'b0, busy_o}, {127'b0, !done_o});
      applyStimulus(i != 35, rnd128(), rnd128(), 1'($urandom()));
    end
    checkOutput("held_done_count", 128'(dones), 128'd6);
    repeat (8) @(negedge clk);

    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      applyStimulus($urandom_range(0, 2) == 0, rnd128(), rnd128(), 1'($urandom()));
      @(negedge clk);
    end
    rst = 1'b0;
    applyStimulus(1'b0, '0, '0, 1'b0);
    repeat (10) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/fwd_round_tf.md
FWD_ROUND_TF -- requirements
Module: fwd_round_tf

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have port start, input, 1 bit: request one forward AES round; sampled only in IDLE.
REQ-004 SHALL have port b_i, input, 128 bits: round input state.
REQ-005 SHALL have port rk_i, input, 128 bits: round key.
REQ-006 SHALL have port bypass_mc, input, 1 bit: when 1, MixColumns is skipped (final round).
REQ-007 SHALL have port b_sr_o, output, 128 bits: registered state after SubBytes+ShiftRows.
REQ-008 SHALL have port b_o, output, 128 bits: registered round result.
REQ-009 SHALL have port done_o, output, 1 bit: one-cycle completion pulse.
REQ-010 SHALL have port busy_o, output, 1 bit: high in any state other than IDLE.

Function
REQ-011 Byte order SHALL be: byte n = b_i[127-8n -: 8]; state[r][c] = byte 4c+r (column-major, FIPS-197).
REQ-012 States SHALL be IDLE, SUB, MIX.
REQ-013 In IDLE with start=1: latch b_i, rk_i, bypass_mc into internal registers; clear column counter to 0; go to SUB.
REQ-014 In SUB: apply the S-box to the 4 bytes of column cnt (exactly 4 S-box instances); cnt increments each cycle; after cnt=3 go to MIX. SUB lasts exactly 4 cycles.
REQ-015 In MIX (1 cycle): compute ShiftRows (row r rotated left by r); MixColumns over GF(2^8), poly 0x11B, matrix [02 03 01 01] circulant, unless latched bypass_mc=1; XOR latched key. Register b_sr_o and b_o; pulse done_o; return to IDLE.
REQ-016 Latency SHALL be: start sampled at edge k -> b_o, b_sr_o valid and done_o=1 during the cycle after edge k+5.
REQ-017 done_o SHALL be high for exactly one cycle per accepted start.
REQ-018 b_o and b_sr_o SHALL hold their values until the next completion or reset.
REQ-019 start while busy_o=1 SHALL be ignored; no queuing occurs.
REQ-020 start in the cycle where done_o=1 SHALL be accepted (state is IDLE); back-to-back issue period is 6 cycles.
REQ-021 Changes on b_i, rk_i, and bypass_mc after acceptance SHALL NOT affect the in-flight result.
REQ-022 cnt SHALL be 2 bits; wrap from 3 coincides with the SUB->MIX transition.

Reset
REQ-023 rst=1 at a rising edge SHALL force: state IDLE, cnt=0, done_o=0, busy_o=0, b_o=0, b_sr_o=0, and clear internal state/key registers.
REQ-024 rst has priority over start; reset mid-operation aborts the round with no done_o pulse.
REQ-025 The first start accepted after rst deasserts SHALL behave identically to one after power-up.

Verification
REQ-026 FIPS-197 App. B round 1: b_i=193de3bea0f4e22b9ac68d2ae9f84808, rk_i=a0fafe1788542cb123a339392a6c7605, bypass_mc=0 -> b_sr_o=d4bf5d30e0b452aeb84111f11e2798e5, b_o=a49c7ff2689f352b6b5bea43026a5049, done_o 5 cycles after start edge.
REQ-027 Final-round path: b_i=0, rk_i=ffff...ff, bypass_mc=1 -> b_sr_o=6363...63, b_o=9c9c...9c.
REQ-028 MixColumns on uniform input: b_i=0, rk_i=0, bypass_mc=0 -> b_sr_o=b_o=6363...63.
REQ-029 start pulsed again during SUB, with b_i changed after acceptance -> single done_o; result matches the originally latched input.
REQ-030 rst asserted at the 3rd SUB cycle -> next cycle all outputs 0, busy_o=0, no done_o; new start then yields REQ-026 values.
REQ-031 start held high continuously -> done_o every 6th cycle; busy_o low only in done_o cycles.
